// File: rtl/mem_access_unit_if.sv
// Data-memory port of the MEM-stage load/store unit: one req/ack access at a time.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I MEM stage: runs one data-memory access per load/store with lane steering
// and load extension, stalls upstream while it is outstanding, drives MEM/WB.
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_valid,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [2:0]               funct3,
  input  logic [31:0]              alu_m,
  input  logic [31:0]              store_data,
  input  logic [4:0]               rd_in,
  input  logic                     reg_write_in,
  mem_access_unit_if.master        dmem,
  output logic                     stall,
  output logic [31:0]              wb_w,
  output logic [4:0]               wb_rd,
  output logic                     wb_regwrite,
  output logic [1:0]               fault
);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] BUSY     = 1'b1;
  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Packs {byte enables, lane-replicated write data}.
  function automatic logic [35:0] store_lanes(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] d);
    logic [35:0] r;
    case (f3[1:0])
      2'b00:   r = {4'b0001 << lo, {4{d[7:0]}}};
      2'b01:   r = {4'b0011 << lo, {2{d[15:0]}}};
      default: r = {4'b1111, d};
    endcase
    return r;
  endfunction

  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic [31:0] wb_w_q, wb_w_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [1:0]  fault_q, fault_d;
  logic        mem_op_s, f3_ok_s, illegal_s, misal_s, stall_s;
  logic [35:0] lanes_s;

  // Decode legality of the op currently presented by EX/MEM.
  always_comb begin
    mem_op_s = mem_valid & (mem_read | mem_write);
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_ok_s = 1'b1;
      3'b100, 3'b101:         f3_ok_s = ~mem_write;
      default:                f3_ok_s = 1'b0;
    endcase
    illegal_s = (mem_read & mem_write) | ~f3_ok_s;
    misal_s   = ((funct3[1:0] == 2'b01) & alu_m[0]) |
                ((funct3[1:0] == 2'b10) & (alu_m[1:0] != 2'b00));
    lanes_s   = store_lanes(funct3, alu_m[1:0], store_data);
  end

  // Next-state, latched access and MEM/WB computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    f3_d          = f3_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    rd_d          = rd_q;
    rw_d          = rw_q;
    wb_w_d        = wb_w_q;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = 1'b0;
    fault_d       = 2'b00;
    stall_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_s) begin
          if (illegal_s) begin
            fault_d = 2'b11;
          end else if (misal_s) begin
            fault_d = 2'b01;
          end else begin
            addr_d  = alu_m;
            f3_d    = funct3;
            we_d    = mem_write;
            be_d    = lanes_s[35:32];
            wdata_d = lanes_s[31:0];
            rd_d    = rd_in;
            rw_d    = reg_write_in;
            cnt_d   = 8'd0;
            stall_s = 1'b1;
            state_d = BUSY;
          end
        end else begin
          wb_w_d        = alu_m;
          wb_rd_d       = rd_in;
          wb_regwrite_d = reg_write_in & mem_valid;
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          state_d = IDLE;
          if (!we_q) begin
            wb_w_d        = load_extend(f3_q, addr_q[1:0], dmem.dmem_rdata);
            wb_rd_d       = rd_q;
            wb_regwrite_d = rw_q;
          end else begin
            wb_regwrite_d = 1'b0;
          end
        end else if (cnt_q == LAST_CNT) begin
          // Abort: the stalled instruction retires as a bubble with a timeout fault.
          state_d = IDLE;
          fault_d = 2'b10;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      addr_q        <= 32'd0;
      f3_q          <= 3'd0;
      we_q          <= 1'b0;
      be_q          <= 4'd0;
      wdata_q       <= 32'd0;
      rd_q          <= 5'd0;
      rw_q          <= 1'b0;
      wb_w_q        <= 32'd0;
      wb_rd_q       <= 5'd0;
      wb_regwrite_q <= 1'b0;
      fault_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      f3_q          <= f3_d;
      we_q          <= we_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      rd_q          <= rd_d;
      rw_q          <= rw_d;
      wb_w_q        <= wb_w_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      fault_q       <= fault_d;
    end
  end

  assign dmem.dmem_req   = (state_q == BUSY);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;
  assign stall           = stall_s & rst_n;
  assign wb_w            = wb_w_q;
  assign wb_rd           = wb_rd_q;
  assign wb_regwrite     = wb_regwrite_q;
  assign fault           = fault_q;
endmodule
